// File: rtl/mm_result_buffer_if.sv
// mm_result_buffer_if: RAM row-write request bus driven by the result buffer
interface mm_result_buffer_if;
  logic         lsu_mm_rbuf_ram_write_vld;
  logic         lsu_mm_rbuf_ram_write_rdy;
  logic [7:0]   lsu_mm_rbuf_ram_write_addr;
  logic [127:0] lsu_mm_rbuf_ram_write_data;
  logic [15:0]  lsu_mm_rbuf_ram_write_strb;
  modport master (
    output lsu_mm_rbuf_ram_write_vld,
    output lsu_mm_rbuf_ram_write_addr,
    output lsu_mm_rbuf_ram_write_data,
    output lsu_mm_rbuf_ram_write_strb,
    input  lsu_mm_rbuf_ram_write_rdy
  );
  modport slave (
    input  lsu_mm_rbuf_ram_write_vld,
    input  lsu_mm_rbuf_ram_write_addr,
    input  lsu_mm_rbuf_ram_write_data,
    input  lsu_mm_rbuf_ram_write_strb,
    output lsu_mm_rbuf_ram_write_rdy
  );
endinterface

// File: rtl/mm_result_buffer.sv
// mm_result_buffer: gathers skewed per-lane MXU bytes into rows and drains them to RAM; MM_RBUF_RELU_EN clamps negative bytes to zero
module mm_result_buffer (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lsu_mm_rbuf_ctrl_vld,
  input  logic [3:0]                lsu_mm_rbuf_ctrl_row_len,
  input  logic [3:0]                lsu_mm_rbuf_ctrl_col_len,
  input  logic [11:0]               lsu_mm_rbuf_ctrl_start_addr,
  input  logic [15:0]               mxu_lsu_rbuf_vld,
  input  logic [127:0]              mxu_lsu_rbuf_data,
  mm_result_buffer_if.master        ram,
  output logic                      lsu_mm_rbuf_done,
  output logic                      lsu_mm_rbuf_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state_q, state_d;
  logic [3:0]        row_len_q, col_len_q, rd_q, rd_d;
  logic [7:0]        base_q;
  logic [15:0][3:0]  ptr_q, ptr_d;
  logic [15:0]       full_q, full_d, cap;
  logic              vld_q, vld_d, done_q, done_d, err_q, err_d;
  logic [127:0]      entry_q [16];
  logic              start, hs, last;
  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^lsu_mm_rbuf_ctrl_start_addr[3:0];
  function automatic logic [7:0] lane_fix(input logic [7:0] b);
`ifdef MM_RBUF_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction
  // a row is ready once every active lane has delivered more than j bytes
  function automatic logic row_ready(input logic [15:0][3:0] p, input logic [15:0] f,
                                     input logic [3:0] j, input logic [3:0] cl);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 16; i++)
      if (4'(i) <= cl && !f[i] && p[i] <= j) r = 1'b0;
    return r;
  endfunction
  assign start = state_q == IDLE && lsu_mm_rbuf_ctrl_vld;
  assign hs    = vld_q && ram.lsu_mm_rbuf_ram_write_rdy;
  assign last  = hs && rd_q == row_len_q;
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // FSM next state: ctrl_vld only starts a job from IDLE, last row handshake ends it
  always_comb
    state_d = state_q == IDLE ? (lsu_mm_rbuf_ctrl_vld ? BUSY : IDLE) : (last ? IDLE : BUSY);
  // per-lane receive pointers, full bits and overflow detection
  always_comb begin
    ptr_d  = ptr_q;
    full_d = full_q;
    err_d  = err_q;
    cap    = '0;
    if (start) begin
      ptr_d  = '0;
      full_d = '0;
      err_d  = 1'b0;
    end else if (state_q == BUSY) begin
      for (int i = 0; i < 16; i++)
        if (mxu_lsu_rbuf_vld[i] && 4'(i) <= col_len_q) begin
          if (full_q[i]) err_d = 1'b1;
          else begin
            cap[i]   = 1'b1;
            ptr_d[i] = ptr_q[i] + 4'd1;
            if (ptr_q[i] == row_len_q) full_d[i] = 1'b1;
          end
        end
    end
  end
  // drain pointer and registered write-valid, looking at next-cycle lane state
  always_comb begin
    rd_d   = start ? 4'd0 : rd_q + {3'd0, hs};
    vld_d  = state_d == BUSY && row_ready(ptr_d, full_d, rd_d, col_len_q);
    done_d = last;
  end
  // job configuration, pointers and status registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_len_q <= '0;
      col_len_q <= '0;
      base_q    <= '0;
      ptr_q     <= '0;
      full_q    <= '0;
      rd_q      <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (start) begin
        row_len_q <= lsu_mm_rbuf_ctrl_row_len;
        col_len_q <= lsu_mm_rbuf_ctrl_col_len;
        base_q    <= lsu_mm_rbuf_ctrl_start_addr[11:4];
      end
      ptr_q  <= ptr_d;
      full_q <= full_d;
      rd_q   <= rd_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  // row storage: each accepted lane byte lands at its own pointer's row
  always_ff @(posedge clk)
    for (int i = 0; i < 16; i++)
      if (cap[i]) entry_q[ptr_q[i]][i*8 +: 8] <= lane_fix(mxu_lsu_rbuf_data[i*8 +: 8]);
  // FSM outputs: write bus zeroed whenever no request is pending
  always_comb begin
    ram.lsu_mm_rbuf_ram_write_vld  = vld_q;
    ram.lsu_mm_rbuf_ram_write_addr = vld_q ? base_q + {4'd0, rd_q} : 8'd0;
    ram.lsu_mm_rbuf_ram_write_data = vld_q ? entry_q[rd_q] : '0;
    ram.lsu_mm_rbuf_ram_write_strb = vld_q ? 16'hFFFF >> (4'd15 - col_len_q) : 16'h0000;
  end
  assign lsu_mm_rbuf_done = done_q;
  assign lsu_mm_rbuf_err  = err_q;
endmodule

// File: tb/tb_mm_result_buffer.sv
// tb_mm_result_buffer: directed self-checking bench for mm_result_buffer
module tb_mm_result_buffer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         ctrl_vld;
  logic [3:0]   row_len, col_len;
  logic [11:0]  start_addr;
  logic [15:0]  mxu_vld;
  logic [127:0] mxu_data;
  logic         done, err;
  logic [127:0] ex;
  int           errs = 0;
  int           checks = 0;
  int           t;
  mm_result_buffer_if bus();
  mm_result_buffer dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .lsu_mm_rbuf_ctrl_vld        (ctrl_vld),
    .lsu_mm_rbuf_ctrl_row_len    (row_len),
    .lsu_mm_rbuf_ctrl_col_len    (col_len),
    .lsu_mm_rbuf_ctrl_start_addr (start_addr),
    .mxu_lsu_rbuf_vld            (mxu_vld),
    .mxu_lsu_rbuf_data           (mxu_data),
    .ram                         (bus),
    .lsu_mm_rbuf_done            (done),
    .lsu_mm_rbuf_err             (err)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] rl(input logic [7:0] b);
`ifdef MM_RBUF_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction
  function automatic logic [127:0] bmask(input logic [15:0] s);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic start_job(input logic [3:0] r, input logic [3:0] c, input logic [11:0] a);
    ctrl_vld = 1'b1; row_len = r; col_len = c; start_addr = a;
    step();
    ctrl_vld = 1'b0;
  endtask
  task automatic drive_rows(input logic [15:0] v, input int j, input logic [7:0] b);
    mxu_vld = v;
    mxu_data = '0;
    for (int i = 0; i < 16; i++) mxu_data[i*8 +: 8] = 8'(b + i*16 + j);
  endtask
  function automatic logic [127:0] row_exp(input int lanes, input int j, input logic [7:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < lanes; i++) r[i*8 +: 8] = rl(8'(b + i*16 + j));
    return r;
  endfunction
  initial begin
    rst_n = 1'b0; ctrl_vld = 1'b0; row_len = '0; col_len = '0; start_addr = '0;
    mxu_vld = '0; mxu_data = '0; bus.lsu_mm_rbuf_ram_write_rdy = 1'b1;
    #3;
    chk("rst_vld",  bus.lsu_mm_rbuf_ram_write_vld, 0);
    chk("rst_addr", bus.lsu_mm_rbuf_ram_write_addr, 0);
    chk("rst_data", bus.lsu_mm_rbuf_ram_write_data, 0);
    chk("rst_strb", bus.lsu_mm_rbuf_ram_write_strb, 0);
    chk("rst_done", done, 0);
    chk("rst_err",  err, 0);
    #10 rst_n = 1'b1;
    step();
    start_job(4'd0, 4'd0, 12'h120);
    mxu_vld = 16'h0003; mxu_data = '0; mxu_data[15:0] = 16'hFF5A;
    chk("basic_vld0", bus.lsu_mm_rbuf_ram_write_vld, 0);
    step();
    mxu_vld = 16'h0002;
    chk("basic_vld",  bus.lsu_mm_rbuf_ram_write_vld, 1);
    chk("basic_addr", bus.lsu_mm_rbuf_ram_write_addr, 8'h12);
    chk("basic_data", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h0001), 128'h5A);
    chk("basic_strb", bus.lsu_mm_rbuf_ram_write_strb, 16'h0001);
    step();
    mxu_vld = '0;
    chk("basic_done",  done, 1);
    chk("basic_vldlo", bus.lsu_mm_rbuf_ram_write_vld, 0);
    chk("basic_datlo", bus.lsu_mm_rbuf_ram_write_data, 0);
    chk("ignore_lane_err", err, 0);
    step();
    chk("basic_done_once", done, 0);
    start_job(4'd3, 4'd15, 12'h340);
    for (int c = 0; c < 22; c++) begin
      mxu_data = '0;
      for (int i = 0; i < 16; i++) begin
        mxu_vld[i] = c >= i && c <= i + 3;
        mxu_data[i*8 +: 8] = 8'(i*16 + c - i);
      end
      step();
      t = c + 1;
      chk("skew_vld", bus.lsu_mm_rbuf_ram_write_vld, t >= 16 && t <= 19);
      if (t >= 16 && t <= 19) begin
        ex = '0;
        for (int i = 0; i < 16; i++) ex[i*8 +: 8] = rl(8'(i*16 + t - 16));
        chk("skew_addr", bus.lsu_mm_rbuf_ram_write_addr, 8'(8'h34 + t - 16));
        chk("skew_data", bus.lsu_mm_rbuf_ram_write_data, ex);
        chk("skew_strb", bus.lsu_mm_rbuf_ram_write_strb, 16'hFFFF);
      end
      chk("skew_done", done, t == 20);
    end
    mxu_vld = '0;
    start_job(4'd2, 4'd1, 12'h500);
    drive_rows(16'h0003, 0, 8'h10);
    step();
    chk("bp_vld0",  bus.lsu_mm_rbuf_ram_write_vld, 1);
    chk("bp_addr0", bus.lsu_mm_rbuf_ram_write_addr, 8'h50);
    chk("bp_data0", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h0003), row_exp(2, 0, 8'h10));
    drive_rows(16'h0003, 1, 8'h10);
    step();
    bus.lsu_mm_rbuf_ram_write_rdy = 1'b0;
    drive_rows(16'h0003, 2, 8'h10);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_vld",  bus.lsu_mm_rbuf_ram_write_vld, 1);
      chk("bp_hold_addr", bus.lsu_mm_rbuf_ram_write_addr, 8'h51);
      chk("bp_hold_data", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h0003), row_exp(2, 1, 8'h10));
      chk("bp_hold_strb", bus.lsu_mm_rbuf_ram_write_strb, 16'h0003);
      step();
      mxu_vld = '0;
    end
    chk("bp_still_addr", bus.lsu_mm_rbuf_ram_write_addr, 8'h51);
    chk("bp_nodone", done, 0);
    bus.lsu_mm_rbuf_ram_write_rdy = 1'b1;
    step();
    chk("bp_addr2", bus.lsu_mm_rbuf_ram_write_addr, 8'h52);
    chk("bp_data2", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h0003), row_exp(2, 2, 8'h10));
    step();
    chk("bp_done", done, 1);
    chk("bp_vld_end", bus.lsu_mm_rbuf_ram_write_vld, 0);
    bus.lsu_mm_rbuf_ram_write_rdy = 1'b0;
    start_job(4'd1, 4'd3, 12'h200);
    drive_rows(16'h000F, 0, 8'h40);
    step();
    chk("ovf_vld", bus.lsu_mm_rbuf_ram_write_vld, 1);
    chk("ovf_err0", err, 0);
    drive_rows(16'h000F, 1, 8'h40);
    step();
    mxu_vld = 16'h0004; mxu_data[23:16] = 8'hEE;
    step();
    mxu_vld = '0;
    chk("ovf_err", err, 1);
    chk("ovf_addr0", bus.lsu_mm_rbuf_ram_write_addr, 8'h20);
    chk("ovf_data0", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h000F), row_exp(4, 0, 8'h40));
    bus.lsu_mm_rbuf_ram_write_rdy = 1'b1;
    step();
    chk("ovf_addr1", bus.lsu_mm_rbuf_ram_write_addr, 8'h21);
    chk("ovf_data1", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h000F), row_exp(4, 1, 8'h40));
    step();
    chk("ovf_done", done, 1);
    chk("ovf_err_sticky", err, 1);
    ctrl_vld = 1'b1; row_len = 4'd1; col_len = 4'd1; start_addr = 12'hFF0;
    step();
    chk("wrap_err_clr", err, 0);
    row_len = 4'd0; col_len = 4'd0; start_addr = 12'h000;
    drive_rows(16'h0003, 0, 8'h01);
    step();
    chk("wrap_vld0",  bus.lsu_mm_rbuf_ram_write_vld, 1);
    chk("wrap_addr0", bus.lsu_mm_rbuf_ram_write_addr, 8'hFF);
    chk("wrap_strb",  bus.lsu_mm_rbuf_ram_write_strb, 16'h0003);
    chk("wrap_data0", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h0003), row_exp(2, 0, 8'h01));
    drive_rows(16'h0003, 1, 8'h01);
    step();
    mxu_vld = '0;
    chk("wrap_vld1",  bus.lsu_mm_rbuf_ram_write_vld, 1);
    chk("wrap_addr1", bus.lsu_mm_rbuf_ram_write_addr, 8'h00);
    chk("wrap_data1", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h0003), row_exp(2, 1, 8'h01));
    step();
    ctrl_vld = 1'b0;
    chk("wrap_done", done, 1);
    chk("wrap_vld_end", bus.lsu_mm_rbuf_ram_write_vld, 0);
    drive_rows(16'h0003, 0, 8'h01);
    step();
    mxu_vld = '0;
    chk("ignore_ctrl_vld",  bus.lsu_mm_rbuf_ram_write_vld, 0);
    chk("ignore_ctrl_done", done, 0);
    start_job(4'd0, 4'd1, 12'h000);
    mxu_vld = 16'h0003; mxu_data = '0; mxu_data[15:0] = 16'h7F80;
    step();
    mxu_vld = '0;
    chk("relu_data", bus.lsu_mm_rbuf_ram_write_data & bmask(16'h0003), {112'd0, rl(8'h7F), rl(8'h80)});
    step();
    chk("relu_done", done, 1);
    bus.lsu_mm_rbuf_ram_write_rdy = 1'b0;
    start_job(4'd0, 4'd0, 12'h7A0);
    mxu_vld = 16'h0001; mxu_data = 128'h11;
    step();
    mxu_vld = '0;
    chk("mid_vld", bus.lsu_mm_rbuf_ram_write_vld, 1);
    chk("mid_addr", bus.lsu_mm_rbuf_ram_write_addr, 8'h7A);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld",  bus.lsu_mm_rbuf_ram_write_vld, 0);
    chk("arst_addr", bus.lsu_mm_rbuf_ram_write_addr, 0);
    chk("arst_data", bus.lsu_mm_rbuf_ram_write_data, 0);
    chk("arst_strb", bus.lsu_mm_rbuf_ram_write_strb, 0);
    #3 rst_n = 1'b1;
    bus.lsu_mm_rbuf_ram_write_rdy = 1'b1;
    step();
    chk("post_rst_vld", bus.lsu_mm_rbuf_ram_write_vld, 0);
    step();
    chk("post_rst_done", done, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
